// File: rtl/tt_uart_top.sv
// Full-duplex UART with runtime frame format (5-8 data bits, none/odd/even parity, 1/2 stops).
// TX and RX are both timed by an external 16x baud tick on ui_in[2]; rst_n is active-high despite its name.
//
// state  | meaning
// IDLE   | line idle; TX waits for tx_start, RX waits for a low line
// START  | start bit (RX: half-bit wait, then false-start check)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit(s); RX completes the frame at the first stop's mid-bit
module tt_uart_top #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam logic [CW-1:0] BIT_TC   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_TC  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] STOP2_TC = CW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic logic [7:0] data_mask(input logic [1:0] nb);
    return 8'hFF >> (2'd3 - nb);
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] nb);
    return 3'd4 + {1'b0, nb};
  endfunction

  function automatic logic [CW-1:0] stop_tc(input logic two);
    return two ? STOP2_TC : BIT_TC;
  endfunction

  logic rst;
  logic tick;
  logic tx_start;
  logic unused_ena;

  assign rst        = rst_n;
  assign tick       = ui_in[2];
  assign tx_start   = ui_in[1];
  assign unused_ena = ena;

  // ---------------- transmitter ----------------
  uart_state_t   tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_par_q, tx_par_d;
  logic          tx_stop2_q, tx_stop2_d;
  logic          tx_pdis_q, tx_pdis_d;
  logic [1:0]    tx_nb_q, tx_nb_d;
  logic          tx_q, tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_pdis_q  <= 1'b0;
      tx_nb_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state   <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_stop2_q <= tx_stop2_d;
      tx_pdis_q  <= tx_pdis_d;
      tx_nb_q    <= tx_nb_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_stop2_d = tx_stop2_q;
    tx_pdis_d  = tx_pdis_q;
    tx_nb_d    = tx_nb_q;
    case (tx_state)
      IDLE: begin
        if (tx_start) begin
          // Parity is fixed at latch time so later config changes cannot alter it.
          tx_sh_d    = uio_in & data_mask(ui_in[4:3]);
          tx_par_d   = (^(uio_in & data_mask(ui_in[4:3]))) ^ ~ui_in[5];
          tx_nb_d    = ui_in[4:3];
          tx_pdis_d  = ui_in[6];
          tx_stop2_d = ui_in[7];
          tx_cnt_d   = BIT_TC;
          tx_state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (tx_cnt_q == '0) begin
            tx_state_d = DATA;
            tx_cnt_d   = BIT_TC;
            tx_idx_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q - CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_cnt_q == '0) begin
            tx_sh_d = tx_sh_q >> 1;
            if (tx_idx_q == last_idx(tx_nb_q)) begin
              tx_state_d = tx_pdis_q ? STOP : PARITY;
              tx_cnt_d   = tx_pdis_q ? stop_tc(tx_stop2_q) : BIT_TC;
            end else begin
              tx_idx_d = tx_idx_q + 3'd1;
              tx_cnt_d = BIT_TC;
            end
          end else begin
            tx_cnt_d = tx_cnt_q - CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (tx_cnt_q == '0) begin
            tx_state_d = STOP;
            tx_cnt_d   = stop_tc(tx_stop2_q);
          end else begin
            tx_cnt_d = tx_cnt_q - CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_cnt_q == '0) tx_state_d = IDLE;
          else                tx_cnt_d   = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = IDLE;
    endcase

    case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_sh_d[0];
      PARITY:  tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  uart_state_t   rx_state, rx_state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_even_q, rx_even_d;
  logic          rx_pdis_q, rx_pdis_d;
  logic [1:0]    rx_nb_q, rx_nb_d;
  logic          rx_perr_q, rx_perr_d;
  logic [7:0]    rx_data, rx_data_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          rx_err_q, rx_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_state  <= IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_even_q <= 1'b0;
      rx_pdis_q <= 1'b0;
      rx_nb_q   <= '0;
      rx_perr_q <= 1'b0;
      rx_data   <= '0;
      rx_rdy_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_meta_q <= ui_in[0];
      rx_sync_q <= rx_meta_q;
      rx_state  <= rx_state_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_even_q <= rx_even_d;
      rx_pdis_q <= rx_pdis_d;
      rx_nb_q   <= rx_nb_d;
      rx_perr_q <= rx_perr_d;
      rx_data   <= rx_data_d;
      rx_rdy_q  <= rx_rdy_d;
      rx_err_q  <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_even_d  = rx_even_q;
    rx_pdis_d  = rx_pdis_q;
    rx_nb_d    = rx_nb_q;
    rx_perr_d  = rx_perr_q;
    rx_data_d  = rx_data;
    rx_rdy_d   = 1'b0;
    rx_err_d   = rx_err_q;
    case (rx_state)
      IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = START;
          rx_cnt_d   = HALF_TC;
          rx_nb_d    = ui_in[4:3];
          rx_even_d  = ui_in[5];
          rx_pdis_d  = ui_in[6];
          rx_sh_d    = '0;
          rx_perr_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_cnt_q == '0) begin
            rx_state_d = rx_sync_q ? IDLE : DATA;
            rx_cnt_d   = BIT_TC;
            rx_idx_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q - CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_cnt_q == '0) begin
            // Shift register was cleared at START, so unused upper bits stay zero.
            rx_sh_d  = rx_sh_q | (8'(rx_sync_q) << rx_idx_q);
            rx_cnt_d = BIT_TC;
            if (rx_idx_q == last_idx(rx_nb_q)) rx_state_d = rx_pdis_q ? STOP : PARITY;
            else                               rx_idx_d   = rx_idx_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q - CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (rx_cnt_q == '0) begin
            rx_perr_d  = rx_sync_q ^ (^rx_sh_q) ^ ~rx_even_q;
            rx_cnt_d   = BIT_TC;
            rx_state_d = STOP;
          end else begin
            rx_cnt_d = rx_cnt_q - CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_cnt_q == '0) begin
            rx_data_d  = rx_sh_q;
            rx_rdy_d   = 1'b1;
            rx_err_d   = rx_perr_q | ~rx_sync_q;
            rx_state_d = IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q - CW'(1);
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  assign uo_out  = {4'b0000, rx_err_q, rx_rdy_q, (tx_state != IDLE), tx_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_uart_top.sv
// Self-checking bench for tt_uart_top: table-driven TX/RX frames, hand sequences for
// tick gating, false start and async reset, plus randomized loopback and RX frames.
module tb_tt_uart_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [4:0] cfg_r;
  logic       start_r, tick_r, rx_drv, loop_r;
  logic [7:0] uio_in_r;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign ui_in = {cfg_r, tick_r, start_r, (loop_r ? uo_out[0] : rx_drv)};

  tt_uart_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in_r),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit         frame_q[$];
  int         rdy_cnt;
  logic [7:0] cap_data;
  logic       cap_err;

  typedef struct {
    logic [4:0] cfg;
    logic [7:0] data;
    int         exp_bits;
  } tx_vec_t;

  typedef struct {
    logic [4:0] cfg;
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_data;
    bit         exp_err;
  } rx_vec_t;

  tx_vec_t tx_tbl[8];
  rx_vec_t rx_tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: the line levels of one frame, one entry per bit period.
  function automatic void build_frame(input logic [4:0] cfg, input logic [7:0] data,
                                      input bit bad_par, input bit bad_stop);
    int n;
    bit p;
    n = 5 + int'(cfg[1:0]);
    p = 1'b0;
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(data[i]);
      p ^= data[i];
    end
    if (!cfg[3]) frame_q.push_back((cfg[2] ? p : !p) ^ bad_par);
    frame_q.push_back(!bad_stop);
    if (cfg[4]) frame_q.push_back(1'b1);
  endfunction

  function automatic logic [7:0] mask_of(input logic [4:0] cfg);
    return 8'((1 << (5 + int'(cfg[1:0]))) - 1);
  endfunction

  task automatic sample_rdy();
    if (uo_out[2]) begin
      rdy_cnt++;
      cap_data = dut.rx_data;
      cap_err  = uo_out[3];
    end
  endtask

  task automatic tx_frame(input logic [4:0] cfg, input logic [7:0] data, input int total,
                          input bit loop, input bit scramble);
    build_frame(cfg, data, 1'b0, 1'b0);
    rdy_cnt = 0;
    @(negedge clk);
    cfg_r    = cfg;
    uio_in_r = data;
    start_r  = 1'b1;
    loop_r   = loop;
    @(posedge clk);
    for (int c = 0; c <= 16 * total; c++) begin
      @(negedge clk);
      if (c == 3) start_r = 1'b0;
      if (scramble && c == 6) begin
        cfg_r    = 5'($urandom);
        uio_in_r = 8'($urandom);
      end
      if (c < 16 * total && c % 16 == 8) check("tx_bit", uo_out[0], frame_q[c / 16]);
      if (c == 16 * total - 1) check("tx_busy_last_cycle", uo_out[1], 1);
      if (c == 16 * total) begin
        check("tx_busy_clear", uo_out[1], 0);
        check("tx_idle_line", uo_out[0], 1);
      end
      sample_rdy();
    end
    if (loop) begin
      check("loop_ready_pulses", rdy_cnt, 1);
      check("loop_rx_data", cap_data, data & mask_of(cfg));
      check("loop_rx_error", cap_err, 0);
    end
    loop_r = 1'b0;
    rx_drv = 1'b1;
  endtask

  task automatic rx_frame(input logic [4:0] cfg, input logic [7:0] data, input bit bad_par,
                          input bit bad_stop, input logic [7:0] exp_data, input bit exp_err);
    build_frame(cfg, data, bad_par, bad_stop);
    rdy_cnt = 0;
    @(negedge clk);
    cfg_r  = cfg;
    loop_r = 1'b0;
    for (int k = 0; k < frame_q.size(); k++)
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        sample_rdy();
        rx_drv = frame_q[k];
      end
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sample_rdy();
      rx_drv = 1'b1;
    end
    check("rx_ready_pulses", rdy_cnt, 1);
    check("rx_data", cap_data, exp_data);
    check("rx_error", cap_err, exp_err);
    check("rx_error_held", uo_out[3], exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_tbl[0] = '{5'b01011, 8'hA5, 10};
    tx_tbl[1] = '{5'b01000, 8'hFF, 7};
    tx_tbl[2] = '{5'b01001, 8'hFF, 8};
    tx_tbl[3] = '{5'b01010, 8'hFF, 9};
    tx_tbl[4] = '{5'b00111, 8'h3C, 11};
    tx_tbl[5] = '{5'b11011, 8'hFF, 11};
    tx_tbl[6] = '{5'b00000, 8'h15, 8};
    tx_tbl[7] = '{5'b10110, 8'h5A, 11};

    rx_tbl[0] = '{5'b01011, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0};
    rx_tbl[1] = '{5'b00111, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    rx_tbl[2] = '{5'b00111, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    rx_tbl[3] = '{5'b01011, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1};
    rx_tbl[4] = '{5'b01011, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0};
    rx_tbl[5] = '{5'b01000, 8'hFF, 1'b0, 1'b0, 8'h1F, 1'b0};
    rx_tbl[6] = '{5'b00010, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0};
    rx_tbl[7] = '{5'b00010, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b1};
    rx_tbl[8] = '{5'b10101, 8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0};
    rx_tbl[9] = '{5'b01001, 8'hC7, 1'b0, 1'b0, 8'h07, 1'b0};

    rst_n    = 1'b1;
    cfg_r    = 5'b01011;
    start_r  = 1'b0;
    tick_r   = 1'b1;
    rx_drv   = 1'b1;
    loop_r   = 1'b0;
    uio_in_r = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 8'h01);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_tx_state", dut.tx_state, 0);
    check("reset_rx_state", dut.rx_state, 0);
    check("reset_rx_data", dut.rx_data, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    foreach (tx_tbl[i]) tx_frame(tx_tbl[i].cfg, tx_tbl[i].data, tx_tbl[i].exp_bits, 1'b0, 1'b0);
    foreach (rx_tbl[i])
      rx_frame(rx_tbl[i].cfg, rx_tbl[i].data, rx_tbl[i].bad_par, rx_tbl[i].bad_stop,
               rx_tbl[i].exp_data, rx_tbl[i].exp_err);

    tx_frame(5'b01000, 8'h1F, 7, 1'b1, 1'b0);

    // False start: a short low glitch must not produce a frame.
    rdy_cnt = 0;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      sample_rdy();
    end
    check("false_start_no_ready", rdy_cnt, 0);
    check("false_start_rx_idle", dut.rx_state, 0);
    check("false_start_data_kept", dut.rx_data, 8'h1F);

    // Timing only advances on tick.
    @(negedge clk);
    tick_r   = 1'b0;
    cfg_r    = 5'b01000;
    uio_in_r = 8'h00;
    start_r  = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    repeat (50) @(negedge clk);
    check("notick_tx_state", dut.tx_state, 1);
    check("notick_tx_line", uo_out[0], 0);
    check("notick_busy", uo_out[1], 1);
    tick_r = 1'b1;
    repeat (15) @(negedge clk);
    check("tick15_still_start", dut.tx_state, 1);
    @(negedge clk);
    check("tick16_data", dut.tx_state, 2);
    repeat (110) @(negedge clk);
    check("tick_frame_done", uo_out[1], 0);

    // Async reset mid-frame on both directions.
    rx_frame(5'b00111, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1);
    @(negedge clk);
    cfg_r    = 5'b01011;
    uio_in_r = 8'hC3;
    start_r  = 1'b1;
    rx_drv   = 1'b0;
    @(negedge clk);
    start_r = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_reset_tx_state", dut.tx_state, 2);
    check("pre_reset_rx_state", dut.rx_state, 2);
    #2 rst_n = 1'b1;
    #1;
    check("midreset_tx_line", uo_out[0], 1);
    check("midreset_busy", uo_out[1], 0);
    check("midreset_ready", uo_out[2], 0);
    check("midreset_error", uo_out[3], 0);
    check("midreset_tx_state", dut.tx_state, 0);
    check("midreset_rx_state", dut.rx_state, 0);
    check("midreset_rx_data", dut.rx_data, 8'h00);
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);

    // Randomized loopback with mid-frame config/data scrambling.
    for (int it = 0; it < 20; it++) begin
      logic [4:0] rc;
      logic [7:0] rd;
      rc = 5'($urandom);
      rd = 8'($urandom);
      build_frame(rc, rd, 1'b0, 1'b0);
      tx_frame(rc, rd, frame_q.size(), 1'b1, 1'b1);
      repeat (4) @(negedge clk);
    end

    // Randomized RX frames with injected parity/stop errors.
    for (int it = 0; it < 15; it++) begin
      logic [4:0] rc;
      logic [7:0] rd;
      bit bp, bs;
      rc = 5'($urandom);
      rd = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0);
      rx_frame(rc, rd, bp, bs, rd & mask_of(rc), (bp && !rc[3]) || bs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
